// File: rtl/ifetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
// Requests use a valid/ready handshake; responses return in order with no backpressure.
interface ifetch_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the fetch PC, keeps up to MAX_OUTSTANDING reads in flight and
// buffers (pc, instr) pairs toward decode. Optional misaligned-redirect fault: IFETCH_MISALIGN_EN.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_unit_if.master mem,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    input  logic          halt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic          out_fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);
    localparam logic [31:0]   WMASK   = 32'hFFFF_FFFC;

`ifdef IFETCH_MISALIGN_EN
    typedef enum logic [1:0] {S_RUN = 2'd0, S_HALTED = 2'd1, S_FAULT = 2'd2} state_t;
`else
    typedef enum logic [0:0] {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;
`endif

    state_t        state_q;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [TW-1:0] trd_q, trd_d, twr_q, twr_d;

    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   tag_q        [MAX_OUTSTANDING];

    logic [CW:0]   credit;
    logic          accept, fresh_rsp, push, pop;
    logic [31:0]   push_pc, push_instr;

`ifdef IFETCH_MISALIGN_EN
    logic          fifo_fault_q [DEPTH];
    logic          fault_pend_q, fault_pend_d;
    logic [31:0]   fault_pc_q;
    logic          misalign, fault_push;
`endif

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit counts every accepted, non-dropped request as already occupying a FIFO slot.
    assign credit        = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q};
    assign mem.req_valid = !rst && !halt && !redirect && (state_q == S_RUN)
                           && (inflight_q < MAXO_C) && (credit < DEPTH_C);
    assign mem.req_addr  = pc_q & WMASK;

    assign accept    = mem.req_valid && mem.req_ready;
    assign fresh_rsp = mem.rsp_valid && !redirect && (drop_q == '0);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_pc    = fifo_pc_q[rd_q];
    assign out_instr = fifo_instr_q[rd_q];

`ifdef IFETCH_MISALIGN_EN
    assign misalign   = redirect && (redirect_pc[1:0] != 2'b00);
    assign fault_push = fault_pend_q && !redirect && (drop_q == '0);
    assign push       = fresh_rsp || fault_push;
    assign push_pc    = fault_push ? fault_pc_q : tag_q[trd_q];
    assign push_instr = fault_push ? 32'h0000_0013 : mem.rsp_data;
    assign out_fault  = out_valid && fifo_fault_q[rd_q];
`else
    assign push       = fresh_rsp;
    assign push_pc    = tag_q[trd_q];
    assign push_instr = mem.rsp_data;
    assign out_fault  = 1'b0;
`endif

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CW'(accept) - CW'(mem.rsp_valid);
        drop_d     = drop_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        rd_d       = pop  ? rd_q + 1'b1 : rd_q;
        wr_d       = push ? wr_q + 1'b1 : wr_q;
        twr_d      = accept        ? tag_next(twr_q) : twr_q;
        trd_d      = mem.rsp_valid ? tag_next(trd_q) : trd_q;
`ifdef IFETCH_MISALIGN_EN
        fault_pend_d = fault_pend_q;
        if (redirect)        fault_pend_d = misalign;
        else if (fault_push) fault_pend_d = 1'b0;
`endif
        if (accept) pc_d = pc_q + 32'd4;
        if (mem.rsp_valid && drop_q != '0) drop_d = drop_q - 1'b1;
        // Redirect wins: whatever is still in flight after this cycle's return becomes stale.
        if (redirect) begin
            pc_d    = redirect_pc & WMASK;
            drop_d  = inflight_q - CW'(mem.rsp_valid);
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            trd_q      <= '0;
            twr_q      <= '0;
`ifdef IFETCH_MISALIGN_EN
            fault_pend_q <= 1'b0;
`endif
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            trd_q      <= trd_d;
            twr_q      <= twr_d;
`ifdef IFETCH_MISALIGN_EN
            fault_pend_q <= fault_pend_d;
            if (misalign)
                state_q <= S_FAULT;
            else if (redirect && state_q == S_FAULT)
                state_q <= halt ? S_HALTED : S_RUN;
            else
`endif
            if (state_q == S_RUN && halt)
                state_q <= S_HALTED;
            else if (state_q == S_HALTED && !halt)
                state_q <= S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tag_q[twr_q] <= pc_q & WMASK;
        if (push) begin
            fifo_pc_q[wr_q]    <= push_pc;
            fifo_instr_q[wr_q] <= push_instr;
        end
`ifdef IFETCH_MISALIGN_EN
        if (push) fifo_fault_q[wr_q] <= fault_push;
        if (misalign) fault_pc_q <= redirect_pc;
`endif
    end

endmodule
